game_time_decoder: RTL and testbench
====================================

GAME_TIME_DECODER -- requirements
Module: game_time_decoder

Interface
REQ-001 Parameter CNT_W, default 10: width of the tenths-of-second count input; supported range 4..13, so the maximum value 8191 fits 4 BCD digits.
REQ-002 CLOCK10M  input  1  single system clock, 10 MHz; all state changes on the rising edge.
REQ-003 KEY0  input  1  reset, asynchronous, active-low.
REQ-004 count_in  input  CNT_W  running game time in tenths of a second, from the 0.1 s counter block.
REQ-005 bcd_out  output  16  {hundreds, tens, units, tenths} BCD digits of the last converted value.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 update  output  1  one-cycle pulse when bcd_out and the HEX outputs take a new value.
REQ-008 HEX0..HEX3  output  7 each  7-segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- HEX0 = tenths, HEX1 = seconds units, HEX2 = tens, HEX3 = hundreds.

Function
REQ-009 The FSM SHALL have the states IDLE and CONV, plus an internal iteration counter of ceil(log2(CNT_W+1)) bits.
REQ-010 In IDLE, conversion start:
- Condition: count_in != last_val at a rising edge.
- At that edge: load count_in into the shift register and into last_val, clear the BCD scratch, set busy, enter CONV.
REQ-011 In CONV, each edge SHALL perform one double-dabble iteration:
- add 3 to every scratch digit >= 5;
- then shift {scratch, shift register} left by 1.
- Exactly CNT_W iterations.
REQ-012 At the edge completing iteration CNT_W:
- write the scratch into bcd_out;
- assert update for exactly one cycle;
- clear busy;
- return to IDLE.
- Latency is CNT_W edges from the load edge to the bcd_out/update edge (10 for the default).
REQ-013 A count_in change while in CONV SHALL be ignored until IDLE.
- IDLE then compares against last_val; a differing value starts a new conversion at the next edge.
- No value is ever queued beyond the latest.
REQ-014 Wrap-around of count_in (e.g. 1023 -> 0) SHALL be converted like any other change.
REQ-015 HEX outputs SHALL be decoded combinationally from the bcd_out register.
- Digit 0-9 mapping: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
- Digit codes 10-15 SHALL display blank (0x7F).
REQ-016 update SHALL never be high in two consecutive cycles.

Reset
REQ-017 While KEY0 = 0, regardless of clock: state IDLE, bcd_out = 0, last_val = 0, busy = 0, update = 0, and the iteration counter and scratch SHALL be cleared.
REQ-018 Reset mid-conversion SHALL abort without an update pulse.
- After release, count_in = 0 produces no conversion.
- Any nonzero count_in starts a conversion at the first edge after release.

Configuration
REQ-019 Macro LEADING_ZERO_BLANK_EN, when defined:
- HEX3 = 0x7F when hundreds = 0;
- HEX2 = 0x7F when hundreds = 0 and tens = 0;
- HEX1 and HEX0 are never blanked.
REQ-020 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always display their value (0 shows 0x40).

Structure
REQ-021 Package game_time_pkg SHALL hold:
- the FSM state enum;
- the SEG_BLANK (0x7F) constant and the digit-to-segment constants;
- the BCD width constant (16).
REQ-022 Sub-module seg7_decode (4-bit digit + blank flag -> 7-bit segments) SHALL be instantiated four times.
- No other sub-modules.

Verification
REQ-023 Reset with count_in = 0, blanking on -> bcd_out 0x0000, HEX0 = HEX1 = 0x40, HEX2 = HEX3 = 0x7F, busy 0, no update pulse.
REQ-024 count_in 0 -> 1023 -> busy for 10 cycles, one update pulse, bcd_out 0x1023, HEX3/2/1/0 = 0x79/0x40/0x24/0x30.
REQ-025 count_in = 57, blanking on -> bcd_out 0x0057, HEX1 = 0x12, HEX0 = 0x78, HEX2 = HEX3 = 0x7F; with the macro off, HEX2 = HEX3 = 0x40.
REQ-026 count_in 100, then 101 during CONV iteration 3 -> first update with 0x0100, second conversion starting 1 edge later, second update with 0x0101, exactly two pulses.
REQ-027 KEY0 low during CONV iteration 5, then released with count_in = 200 -> bcd_out 0 and no pulse during reset; afterwards one conversion, bcd_out 0x0200.
REQ-028 count_in 1023 -> 0 wrap -> one update, bcd_out 0x0000.

Source files
------------

// File: rtl/game_time_pkg.sv
// game_time_pkg: shared types, segment constants and the double-dabble digit adjust step.
package game_time_pkg;
  typedef enum logic {IDLE, CONV} state_t;
  localparam int BCD_W = 16;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_TAB = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < BCD_W / 4; i++)
      r[i*4 +: 4] = s[i*4 +: 4] >= 4'd5 ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
    return r;
  endfunction
endpackage

// File: rtl/game_time_decoder_if.sv
// game_time_decoder_if: count input plus BCD/status/7-segment outputs of the game time decoder.
interface game_time_decoder_if #(parameter int CNT_W = 10);
  logic [CNT_W-1:0] count_in;
  logic [15:0] bcd_out;
  logic busy;
  logic update;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  modport master (output count_in, input bcd_out, busy, update, HEX0, HEX1, HEX2, HEX3);
  modport slave (input count_in, output bcd_out, busy, update, HEX0, HEX1, HEX2, HEX3);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: one BCD digit to active-low {g,f,e,d,c,b,a} segments, codes 10-15 and blank show dark.
module seg7_decode
  import game_time_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : SEG_TAB[digit];
endmodule

// File: rtl/game_time_decoder.sv
// game_time_decoder: serial double-dabble conversion of the tenths-of-second count to 4 BCD digits + 7-seg.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module game_time_decoder
  import game_time_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input logic CLOCK10M,
  input logic KEY0,
  game_time_decoder_if.slave bus
);
  localparam int IT_W = $clog2(CNT_W + 1);
  state_t state;
  logic [IT_W-1:0] it_cnt;
  logic [CNT_W-1:0] shreg, last_val;
  logic [BCD_W-1:0] scratch, adj, next_scratch, bcd_r;
  logic busy_r, update_r, blank3, blank2;
  assign adj = dabble_adjust(scratch);
  assign next_scratch = {adj[BCD_W-2:0], shreg[CNT_W-1]};
  always_ff @(posedge CLOCK10M or negedge KEY0) begin
    if (!KEY0) begin
      state <= IDLE;
      it_cnt <= '0;
      shreg <= '0;
      last_val <= '0;
      scratch <= '0;
      bcd_r <= '0;
      busy_r <= 1'b0;
      update_r <= 1'b0;
    end else begin
      update_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.count_in != last_val) begin
          shreg <= bus.count_in;
          last_val <= bus.count_in;
          scratch <= '0;
          it_cnt <= '0;
          busy_r <= 1'b1;
          state <= CONV;
        end
      end else begin
        scratch <= next_scratch;
        shreg <= shreg << 1;
        it_cnt <= it_cnt + 1'b1;
        if (it_cnt == IT_W'(CNT_W - 1)) begin
          bcd_r <= next_scratch;
          update_r <= 1'b1;
          busy_r <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
`ifdef LEADING_ZERO_BLANK_EN
  assign blank3 = bcd_r[15:12] == 4'd0;
  assign blank2 = blank3 && bcd_r[11:8] == 4'd0;
`else
  assign blank3 = 1'b0;
  assign blank2 = 1'b0;
`endif
  assign bus.bcd_out = bcd_r;
  assign bus.busy = busy_r;
  assign bus.update = update_r;
  seg7_decode u_hex0 (.digit(bcd_r[3:0]), .blank(1'b0), .seg(bus.HEX0));
  seg7_decode u_hex1 (.digit(bcd_r[7:4]), .blank(1'b0), .seg(bus.HEX1));
  seg7_decode u_hex2 (.digit(bcd_r[11:8]), .blank(blank2), .seg(bus.HEX2));
  seg7_decode u_hex3 (.digit(bcd_r[15:12]), .blank(blank3), .seg(bus.HEX3));
endmodule

// File: tb/tb_game_time_decoder.sv
// tb_game_time_decoder: table-driven vectors with a scoreboard of expected BCD results per update pulse.
module tb_game_time_decoder;
  logic clk = 1'b0;
  logic KEY0 = 1'b0;
  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  logic prev_upd = 1'b0;
  logic [15:0] sb[$];
  typedef struct {
    logic [9:0]  cnt;
    logic [15:0] bcd;
  } vec_t;
  vec_t vecs[7];

  game_time_decoder_if #(.CNT_W(10)) bus();
  game_time_decoder #(.CNT_W(10)) dut (.CLOCK10M(clk), .KEY0(KEY0), .bus(bus));

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] hex_exp(input logic [15:0] b, input int idx);
    logic [3:0] d;
    d = b[idx*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3 && b[15:12] == 4'd0) return 7'h7F;
    if (idx == 2 && b[15:8] == 8'd0) return 7'h7F;
`endif
    return seg_of(d);
  endfunction

  task automatic check_hex(input string tag, input logic [15:0] b);
    check({tag, "_hex0"}, 32'(bus.HEX0), 32'(hex_exp(b, 0)));
    check({tag, "_hex1"}, 32'(bus.HEX1), 32'(hex_exp(b, 1)));
    check({tag, "_hex2"}, 32'(bus.HEX2), 32'(hex_exp(b, 2)));
    check({tag, "_hex3"}, 32'(bus.HEX3), 32'(hex_exp(b, 3)));
  endtask

  always @(negedge clk) begin
    if (bus.update) begin
      upd_cnt++;
      check("upd_gap", 32'(prev_upd), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_update", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("bcd_out", 32'(bus.bcd_out), 32'(e));
        check_hex("upd", e);
      end
    end
    prev_upd = bus.update;
  end

  task automatic wait_update(input int max, output int n, output int bc);
    n = -1;
    bc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.update) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic drive(input logic [9:0] v);
    @(posedge clk);
    #1 bus.count_in = v;
  endtask

  initial begin
    int n, bc, u0;
    vecs[0] = '{10'd1023, 16'h1023};
    vecs[1] = '{10'd57, 16'h0057};
    vecs[2] = '{10'd999, 16'h0999};
    vecs[3] = '{10'd1, 16'h0001};
    vecs[4] = '{10'd500, 16'h0500};
    vecs[5] = '{10'd1023, 16'h1023};
    vecs[6] = '{10'd0, 16'h0000};
    bus.count_in = '0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bus.bcd_out), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_update", 32'(bus.update), 32'd0);
    check_hex("rst", 16'h0000);
    @(posedge clk);
    #1 KEY0 = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_no_upd", 32'(upd_cnt), 32'd0);
    for (int k = 0; k < 7; k++) begin
      drive(vecs[k].cnt);
      sb.push_back(vecs[k].bcd);
      wait_update(40, n, bc);
      check("latency", 32'(n), 32'd12);
      check("busy_cycles", 32'(bc), 32'd10);
      repeat (2) @(negedge clk);
      check("post_busy", 32'(bus.busy), 32'd0);
    end
    check("vec_updates", 32'(upd_cnt), 32'd7);
    // Change arrives mid-conversion: held off until IDLE, then converted once
    u0 = upd_cnt;
    drive(10'd100);
    sb.push_back(16'h0100);
    repeat (3) @(posedge clk);
    #1 bus.count_in = 10'd101;
    sb.push_back(16'h0101);
    wait_update(40, n, bc);
    check("first_lat", 32'(n), 32'd9);
    wait_update(40, n, bc);
    check("second_lat", 32'(n), 32'd11);
    repeat (15) @(negedge clk);
    check("two_pulses", 32'(upd_cnt - u0), 32'd2);
    // Reset during iteration 5 aborts the conversion silently
    u0 = upd_cnt;
    drive(10'd300);
    repeat (5) @(posedge clk);
    #1 KEY0 = 1'b0;
    bus.count_in = 10'd200;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_bcd", 32'(bus.bcd_out), 32'h0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
    end
    check("mid_rst_no_upd", 32'(upd_cnt - u0), 32'd0);
    @(posedge clk);
    #1 KEY0 = 1'b1;
    sb.push_back(16'h0200);
    wait_update(40, n, bc);
    check("rel_lat", 32'(n), 32'd12);
    repeat (15) @(negedge clk);
    check("rel_one_upd", 32'(upd_cnt - u0), 32'd1);
    // Release with zero count: matches cleared last_val, nothing to convert
    u0 = upd_cnt;
    @(posedge clk);
    #1 KEY0 = 1'b0;
    bus.count_in = 10'd0;
    @(negedge clk);
    check("zero_rst_bcd", 32'(bus.bcd_out), 32'h0);
    @(posedge clk);
    #1 KEY0 = 1'b1;
    bc = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    check("zero_no_busy", 32'(bc), 32'd0);
    check("zero_no_upd", 32'(upd_cnt - u0), 32'd0);
    check_hex("zero", 16'h0000);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
